regfile_write_queue: RTL and testbench
======================================

// Module: regfile_write_queue
// PURPOSE
//   Buffers register-file write requests from the writeback stage and drains
//   them, one per cycle, into the 32x32 register file's single write port
//   (RegWrite/WriteRegister/WriteData). Supplies read-forwarding of pending
//   writes so operand readers see the youngest value before the regfile commits.
//   Sits directly upstream of the register file.
// PARAMETERS
//   DEPTH  4   queue entries; power of two, >= 2
//   AW     2   pointer width, = log2(DEPTH)
// PORTS
//   Clk            in   1   clock, posedge
//   Reset_n        in   1   asynchronous active-low reset
//   InValid        in   1   write request valid
//   InReady        out  1   queue can accept; combinational, = (Count != DEPTH)
//   InRegister     in   5   destination register of request
//   InData         in   32  data of request
//   DrainEn        in   1   high: head may be popped this cycle
//   RegWrite       out  1   regfile write enable (registered)
//   WriteRegister  out  5   regfile write address (registered)
//   WriteData      out  32  regfile write data (registered)
//   ReadRegister1  in   5   read port 1 address (shared with regfile)
//   ReadRegister2  in   5   read port 2 address (shared with regfile)
//   FwdHit1        out  1   pending write to ReadRegister1 exists
//   FwdData1       out  32  youngest pending data for ReadRegister1, 0 if no hit
//   FwdHit2        out  1   as FwdHit1 for port 2
//   FwdData2       out  32  as FwdData1 for port 2
//   Count          out  AW+1  occupied entries, 0..DEPTH
// BEHAVIOUR
//   - Reset (async, Reset_n=0): pointers and Count=0, all entries invalid,
//     RegWrite=0, WriteRegister=0, WriteData=0. Reset mid-operation drops all
//     pending writes; no RegWrite pulse follows reset release.
//   - Accept at posedge when InValid && InReady. InRegister==0: handshake
//     completes but nothing is enqueued (R0 is hardwired zero).
//   - Pop at posedge when DrainEn && Count!=0: head loaded into WriteRegister/
//     WriteData, RegWrite=1 for that following cycle; else RegWrite=0 next cycle.
//     Regfile commits at the next edge. Latency: accepted edge N -> RegWrite
//     high in cycle after edge N+1 (empty queue, DrainEn=1) -> committed edge N+2.
//   - No same-edge enqueue-to-output bypass: an entry accepted into an empty
//     queue is popped at the earliest on the following edge.
//   - Simultaneous accept and pop: Count unchanged; both take effect.
//   - InReady computed from current Count only; a pop in the same cycle does
//     not raise InReady when full.
//   - Pointers wrap modulo DEPTH; order strictly FIFO.
//   - Forwarding (combinational): search the output stage (if RegWrite) and
//     all valid entries; youngest match wins (newest queue entry > older >
//     output stage). Address 0 never hits. Same-cycle incoming request is not
//     forwarded.
//   - Duplicate addresses in the queue are all written in order; no merging.
// TESTING
//   1. Reset; enqueue (2,42), DrainEn=1 -> RegWrite=1,WriteRegister=2,
//      WriteData=42 for exactly one cycle, 2 edges after accept; Count back to 0.
//   2. DrainEn=0; enqueue (1,11),(2,22),(3,33),(4,44) -> Count=4, InReady=0;
//      5th request held; DrainEn=1 -> writes 1,2,3,4 on consecutive cycles.
//   3. Enqueue (0,3410) -> InReady handshake completes, Count stays 0, no RegWrite.
//   4. DrainEn=0; enqueue (5,100),(5,200); ReadRegister1=5, ReadRegister2=6
//      -> FwdHit1=1, FwdData1=200; FwdHit2=0, FwdData2=0.
//   5. Three entries pending; Reset_n low mid-cycle -> Count=0, RegWrite=0
//      immediately; after release no write pulses occur.
//   6. Wrap: 10 back-to-back enqueues (r=i, d=i*7) with DrainEn=1 -> 10 writes
//      in order, data i*7, no loss or duplication.

Source files
------------

// File: rtl/regfile_write_queue_if.sv
// Bundle between the writeback stage, the write queue and the operand readers.
// A request transfers on a rising edge where InValid && InReady; InReady depends only on occupancy.
interface regfile_write_queue_if #(
    parameter int AW = 2
);
    logic          InValid;
    logic          InReady;
    logic [4:0]    InRegister;
    logic [31:0]   InData;
    logic          DrainEn;
    logic          RegWrite;
    logic [4:0]    WriteRegister;
    logic [31:0]   WriteData;
    logic [4:0]    ReadRegister1;
    logic [4:0]    ReadRegister2;
    logic          FwdHit1;
    logic [31:0]   FwdData1;
    logic          FwdHit2;
    logic [31:0]   FwdData2;
    logic [AW:0]   Count;

    modport master (
        output InValid, InRegister, InData, DrainEn, ReadRegister1, ReadRegister2,
        input  InReady, RegWrite, WriteRegister, WriteData,
        input  FwdHit1, FwdData1, FwdHit2, FwdData2, Count
    );

    modport slave (
        input  InValid, InRegister, InData, DrainEn, ReadRegister1, ReadRegister2,
        output InReady, RegWrite, WriteRegister, WriteData,
        output FwdHit1, FwdData1, FwdHit2, FwdData2, Count
    );
endinterface

// File: rtl/regfile_write_queue.sv
// FIFO of pending register-file writes, drained one per cycle into the regfile write port,
// with combinational forwarding of the youngest pending value to two read ports.
module regfile_write_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    regfile_write_queue_if.slave   bus
);
    logic [4:0]    r_entry_reg  [DEPTH];
    logic [31:0]   r_entry_data [DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [AW:0]   r_count;
    logic          r_reg_write;
    logic [4:0]    r_write_register;
    logic [31:0]   r_write_data;

    logic          w_in_ready;
    logic          w_push;
    logic          w_pop;
    logic [4:0]    w_raddr [2];

    assign w_in_ready = (r_count != (AW+1)'(DEPTH));
    // R0 requests complete the handshake but are never stored
    assign w_push     = bus.InValid && w_in_ready && (bus.InRegister != 5'd0);
    assign w_pop      = bus.DrainEn && (r_count != '0);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_head           <= '0;
            r_tail           <= '0;
            r_count          <= '0;
            r_reg_write      <= 1'b0;
            r_write_register <= '0;
            r_write_data     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_entry_reg[i]  <= '0;
                r_entry_data[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_entry_reg[r_tail]  <= bus.InRegister;
                r_entry_data[r_tail] <= bus.InData;
                r_tail               <= r_tail + AW'(1);
            end
            if (w_pop) begin
                r_head           <= r_head + AW'(1);
                r_reg_write      <= 1'b1;
                r_write_register <= r_entry_reg[r_head];
                r_write_data     <= r_entry_data[r_head];
            end else begin
                r_reg_write      <= 1'b0;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_raddr[0] = bus.ReadRegister1;
    assign w_raddr[1] = bus.ReadRegister2;

    for (genvar p = 0; p < 2; p++) begin : g_fwd
        logic          w_hit;
        logic [31:0]   w_fdata;
        logic [AW-1:0] w_idx;

        // Scan oldest to newest so the youngest match is the one left standing
        always_comb begin
            w_hit   = 1'b0;
            w_fdata = '0;
            w_idx   = '0;
            if (w_raddr[p] != 5'd0) begin
                if (r_reg_write && (r_write_register == w_raddr[p])) begin
                    w_hit   = 1'b1;
                    w_fdata = r_write_data;
                end
                for (int i = 0; i < DEPTH; i++) begin
                    w_idx = r_head + AW'(i);
                    if (((AW+1)'(i) < r_count) && (r_entry_reg[w_idx] == w_raddr[p])) begin
                        w_hit   = 1'b1;
                        w_fdata = r_entry_data[w_idx];
                    end
                end
            end
        end
    end

    assign bus.InReady       = w_in_ready;
    assign bus.RegWrite      = r_reg_write;
    assign bus.WriteRegister = r_write_register;
    assign bus.WriteData     = r_write_data;
    assign bus.Count         = r_count;
    assign bus.FwdHit1       = g_fwd[0].w_hit;
    assign bus.FwdData1      = g_fwd[0].w_fdata;
    assign bus.FwdHit2       = g_fwd[1].w_hit;
    assign bus.FwdData2      = g_fwd[1].w_fdata;
endmodule

// File: tb/tb_regfile_write_queue.sv
// Bench for regfile_write_queue: directed scenarios plus random traffic against a
// queue-based reference of pending writes and a scoreboard of expected regfile writes.
module tb_regfile_write_queue;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic Clk     = 1'b0;
    logic Reset_n = 1'b0;
    always #5 Clk = ~Clk;

    regfile_write_queue_if #(.AW(AW)) bus ();

    regfile_write_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus.slave)
    );

    int checks  = 0;
    int errors  = 0;
    int wr_seen = 0;
    bit mon_en  = 1'b0;

    // {register, data}
    logic [36:0] exp_q [$];
    logic [36:0] pend  [$];
    logic        m_out_v = 1'b0;
    logic [36:0] m_out   = '0;
    bit          m_pop;
    bit          m_acc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fwd_model(input logic [4:0] a, output logic hit, output logic [31:0] d);
        hit = 1'b0;
        d   = '0;
        if (a != 5'd0) begin
            if (m_out_v && m_out[36:32] == a) begin
                hit = 1'b1;
                d   = m_out[31:0];
            end
            foreach (pend[i]) begin
                if (pend[i][36:32] == a) begin
                    hit = 1'b1;
                    d   = pend[i][31:0];
                end
            end
        end
    endtask

    // Reference model: pending writes as a plain queue, output stage as one slot
    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pend.delete();
            exp_q.delete();
            m_out_v = 1'b0;
            m_out   = '0;
        end else begin
            m_pop = bus.DrainEn && (pend.size() != 0);
            m_acc = bus.InValid && (pend.size() != DEPTH);
            if (m_pop) begin
                m_out   = pend.pop_front();
                m_out_v = 1'b1;
            end else begin
                m_out_v = 1'b0;
            end
            if (m_acc && bus.InRegister != 5'd0) begin
                pend.push_back({bus.InRegister, bus.InData});
                exp_q.push_back({bus.InRegister, bus.InData});
            end
        end
    end

    // Monitor: compares every cycle, pops the scoreboard on each regfile write
    always @(negedge Clk) begin
        logic [36:0] e;
        logic        h;
        logic [31:0] d;
        if (mon_en) begin
            chk("count", 32'(bus.Count), 32'(pend.size()));
            chk("in_ready", 32'(bus.InReady), 32'(pend.size() != DEPTH));
            chk("reg_write", 32'(bus.RegWrite), 32'(m_out_v));
            if (bus.RegWrite === 1'b1) begin
                wr_seen++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write reg=%0d data=%0d expected=none at %0t",
                             bus.WriteRegister, bus.WriteData, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("write_register", 32'(bus.WriteRegister), 32'(e[36:32]));
                    chk("write_data", bus.WriteData, e[31:0]);
                end
            end
            fwd_model(bus.ReadRegister1, h, d);
            chk("fwd_hit1", 32'(bus.FwdHit1), 32'(h));
            chk("fwd_data1", bus.FwdData1, d);
            fwd_model(bus.ReadRegister2, h, d);
            chk("fwd_hit2", 32'(bus.FwdHit2), 32'(h));
            chk("fwd_data2", bus.FwdData2, d);
        end
    end

    task automatic cycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.InValid = 1'b0;
        repeat (n) cycle();
    endtask

    initial begin
        int w;
        int budget;
        bus.InValid       = 1'b0;
        bus.InRegister    = '0;
        bus.InData        = '0;
        bus.DrainEn       = 1'b0;
        bus.ReadRegister1 = '0;
        bus.ReadRegister2 = '0;
        mon_en            = 1'b1;
        repeat (2) cycle();
        chk("reset_count", 32'(bus.Count), 0);
        chk("reset_reg_write", 32'(bus.RegWrite), 0);
        chk("reset_write_register", 32'(bus.WriteRegister), 0);
        chk("reset_write_data", bus.WriteData, 0);
        Reset_n = 1'b1;
        cycle();

        // Single write latency
        bus.DrainEn = 1'b1;
        bus.InValid = 1'b1; bus.InRegister = 5'd2; bus.InData = 32'd42;
        cycle();
        bus.InValid = 1'b0;
        chk("t1_no_bypass", 32'(bus.RegWrite), 0);
        cycle();
        chk("t1_reg_write", 32'(bus.RegWrite), 1);
        chk("t1_write_register", 32'(bus.WriteRegister), 2);
        chk("t1_write_data", bus.WriteData, 42);
        cycle();
        chk("t1_pulse_end", 32'(bus.RegWrite), 0);
        chk("t1_count", 32'(bus.Count), 0);

        // Fill, hold a fifth request, then drain
        bus.DrainEn = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            bus.InValid = 1'b1; bus.InRegister = 5'(i); bus.InData = 32'(i * 11);
            cycle();
        end
        bus.InRegister = 5'd5; bus.InData = 32'd55;
        cycle();
        cycle();
        chk("t2_full_count", 32'(bus.Count), 4);
        chk("t2_full_ready", 32'(bus.InReady), 0);
        bus.DrainEn = 1'b1;
        cycle();
        chk("t2_wr1", 32'(bus.WriteRegister), 1);
        cycle();
        bus.InValid = 1'b0;
        chk("t2_wr2", 32'(bus.WriteRegister), 2);
        cycle();
        chk("t2_wr3", 32'(bus.WriteRegister), 3);
        cycle();
        chk("t2_wr4", 32'(bus.WriteRegister), 4);
        chk("t2_wr4_data", bus.WriteData, 44);
        cycle();
        chk("t2_wr5_data", bus.WriteData, 55);
        cycle();
        chk("t2_drained", 32'(bus.Count), 0);

        // Write to R0 is swallowed
        bus.InValid = 1'b1; bus.InRegister = 5'd0; bus.InData = 32'd3410;
        chk("t3_ready", 32'(bus.InReady), 1);
        cycle();
        bus.InValid = 1'b0;
        chk("t3_count", 32'(bus.Count), 0);
        cycle();
        chk("t3_no_write", 32'(bus.RegWrite), 0);

        // Forwarding of youngest duplicate
        bus.DrainEn = 1'b0;
        bus.InValid = 1'b1; bus.InRegister = 5'd5; bus.InData = 32'd100;
        cycle();
        bus.InData = 32'd200;
        cycle();
        bus.InValid = 1'b0;
        bus.ReadRegister1 = 5'd5; bus.ReadRegister2 = 5'd6;
        #1;
        chk("t4_hit1", 32'(bus.FwdHit1), 1);
        chk("t4_data1", bus.FwdData1, 200);
        chk("t4_hit2", 32'(bus.FwdHit2), 0);
        chk("t4_data2", bus.FwdData2, 0);
        bus.DrainEn = 1'b1;
        idle(4);

        // Reset mid-operation drops pending writes
        bus.DrainEn = 1'b0;
        idle(2);
        for (int i = 7; i <= 9; i++) begin
            bus.InValid = 1'b1; bus.InRegister = 5'(i); bus.InData = 32'(i - 6);
            cycle();
        end
        bus.InValid = 1'b0;
        bus.ReadRegister1 = 5'd7;
        chk("t5_pending", 32'(bus.Count), 3);
        #3;
        Reset_n = 1'b0;
        #1;
        chk("t5_count", 32'(bus.Count), 0);
        chk("t5_reg_write", 32'(bus.RegWrite), 0);
        chk("t5_fwd", 32'(bus.FwdHit1), 0);
        w = wr_seen;
        cycle();
        cycle();
        Reset_n = 1'b1;
        bus.DrainEn = 1'b1;
        idle(5);
        chk("t5_no_writes", 32'(wr_seen - w), 0);

        // Back-to-back with wrap
        w = wr_seen;
        for (int i = 1; i <= 10; i++) begin
            bus.InValid = 1'b1; bus.InRegister = 5'(i); bus.InData = 32'(i * 7);
            cycle();
        end
        idle(4);
        chk("t6_write_count", 32'(wr_seen - w), 10);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            bus.InValid       = ($urandom_range(0, 3) != 0);
            bus.InRegister    = 5'($urandom_range(0, 7));
            bus.InData        = $urandom;
            bus.DrainEn       = ($urandom_range(0, 2) != 0);
            bus.ReadRegister1 = 5'($urandom_range(0, 7));
            bus.ReadRegister2 = 5'($urandom_range(0, 31));
            cycle();
        end
        bus.DrainEn = 1'b1;
        bus.InValid = 1'b0;
        budget = 0;
        while ((exp_q.size() != 0 || bus.RegWrite) && budget < 20) begin
            cycle();
            budget++;
        end
        cycle();
        chk("scoreboard_empty", 32'(exp_q.size()), 0);

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
